// File: rtl/hazard3_clint_timer.sv
// hazard3_clint_timer
//   CLINT-style machine timer and software-interrupt block behind a
//   zero-wait-state APB slave.
//
//   Ports
//     clk, rst_n          sole clock; asynchronous active-low reset
//     paddr/psel/penable/ APB request; a transfer completes when
//     pwrite/pwdata       psel && penable
//     prdata              read data, combinational from paddr
//     pready              always 1
//     pslverr             unmapped address during the access phase
//     dbg_halt            freezes time while high
//     tick                time-base event, one per high cycle
//     soft_irq            per-hart registered copy of MSIP
//     timer_irq           per-hart registered (mtime >= MTIMECMP)
module hazard3_clint_timer #(
   parameter int unsigned N_HARTS    = 1,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [15:0]        paddr,
   input  logic               psel,
   input  logic               penable,
   input  logic               pwrite,
   input  logic [31:0]        pwdata,
   output logic [31:0]        prdata,
   output logic               pready,
   output logic               pslverr,
   input  logic               dbg_halt,
   input  logic               tick,
   output logic [N_HARTS-1:0] soft_irq,
   output logic [N_HARTS-1:0] timer_irq
);

   logic                           en_q, en_d;
   logic [PRESCALE_W-1:0]          presc_q, presc_d;
   logic [PRESCALE_W-1:0]          cnt_q, cnt_d;
   logic [63:0]                    mtime_q, mtime_d;
   logic [31:0]                    shadow_q, shadow_d;
   logic [N_HARTS-1:0]             msip_q, msip_d;
   logic [N_HARTS-1:0][63:0]       cmp_q, cmp_d;
   logic [N_HARTS-1:0]             soft_irq_q, timer_irq_q;

   logic                           sel_ctrl, sel_presc, sel_mtime, sel_mtimeh;
   logic [N_HARTS-1:0]             sel_msip, sel_cmpl, sel_cmph;
   logic                           hit;
   logic                           xfer, wr, rd;
   logic                           tick_now, inc;
   logic [N_HARTS-1:0]             timer_hit;

   assign xfer     = psel & penable;
   assign wr       = xfer & pwrite;
   assign rd       = xfer & ~pwrite;
   assign tick_now = tick & en_q & ~dbg_halt;

   // Address decode; per-hart windows only exist for h < N_HARTS.
   always_comb begin
      sel_ctrl   = (paddr == 16'h0000);
      sel_presc  = (paddr == 16'h0004);
      sel_mtime  = (paddr == 16'h0008);
      sel_mtimeh = (paddr == 16'h000C);
      sel_msip   = '0;
      sel_cmpl   = '0;
      sel_cmph   = '0;
      for (int unsigned h = 0; h < N_HARTS; h++) begin
         sel_msip[h] = (paddr == 16'h0100 + 16'(h * 4));
         sel_cmpl[h] = (paddr == 16'h0200 + 16'(h * 8));
         sel_cmph[h] = (paddr == 16'h0204 + 16'(h * 8));
      end
      hit = sel_ctrl | sel_presc | sel_mtime | sel_mtimeh |
            (|sel_msip) | (|sel_cmpl) | (|sel_cmph);
   end

   always_comb begin
      prdata = '0;
      if (sel_ctrl)   prdata[0] = en_q;
      if (sel_presc)  prdata[PRESCALE_W-1:0] = presc_q;
      if (sel_mtime)  prdata = mtime_q[31:0];
      if (sel_mtimeh) prdata = shadow_q;
      for (int unsigned h = 0; h < N_HARTS; h++) begin
         if (sel_msip[h]) prdata[0] = msip_q[h];
         if (sel_cmpl[h]) prdata = cmp_q[h][31:0];
         if (sel_cmph[h]) prdata = cmp_q[h][63:32];
      end
   end

   assign pready  = 1'b1;
   assign pslverr = xfer & ~hit;

   always_comb begin
      en_d     = en_q;
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      mtime_d  = mtime_q;
      shadow_d = shadow_q;
      msip_d   = msip_q;
      cmp_d    = cmp_q;
      inc      = 1'b0;

      if (tick_now) begin
         if (cnt_q == presc_q) begin
            cnt_d = '0;
            inc   = 1'b1;
         end else begin
            cnt_d = cnt_q + PRESCALE_W'(1);
         end
      end
      if (inc) mtime_d = mtime_q + 64'd1;

      // Latch the upper half at the moment the lower half is read so a
      // following MTIMEH read forms a coherent 64-bit sample.
      if (rd && sel_mtime) shadow_d = mtime_q[63:32];

      if (wr) begin
         if (sel_ctrl) en_d = pwdata[0];
         if (sel_presc) begin
            presc_d = pwdata[PRESCALE_W-1:0];
            cnt_d   = '0;
         end
         // Half writes are built from mtime_q, discarding any increment
         // this cycle so no carry crosses into the untouched half.
         if (sel_mtime) mtime_d = {mtime_q[63:32], pwdata};
         if (sel_mtimeh) begin
            mtime_d  = {pwdata, mtime_q[31:0]};
            shadow_d = pwdata;
         end
         for (int unsigned h = 0; h < N_HARTS; h++) begin
            if (sel_msip[h]) msip_d[h] = pwdata[0];
            if (sel_cmpl[h]) cmp_d[h][31:0]  = pwdata;
            if (sel_cmph[h]) cmp_d[h][63:32] = pwdata;
         end
      end
   end

   always_comb begin
      timer_hit = '0;
      for (int unsigned h = 0; h < N_HARTS; h++) begin
         timer_hit[h] = (mtime_q >= cmp_q[h]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q        <= 1'b1;
         presc_q     <= '0;
         cnt_q       <= '0;
         mtime_q     <= '0;
         shadow_q    <= '0;
         msip_q      <= '0;
         cmp_q       <= '1;
         soft_irq_q  <= '0;
         timer_irq_q <= '0;
      end else begin
         en_q        <= en_d;
         presc_q     <= presc_d;
         cnt_q       <= cnt_d;
         mtime_q     <= mtime_d;
         shadow_q    <= shadow_d;
         msip_q      <= msip_d;
         cmp_q       <= cmp_d;
         soft_irq_q  <= msip_q;
         timer_irq_q <= timer_hit;
      end
   end

   assign soft_irq  = soft_irq_q;
   assign timer_irq = timer_irq_q;

endmodule

// File: doc/hazard3_clint_timer.md
HAZARD3_CLINT_TIMER -- requirements
Module: hazard3_clint_timer

Interface
REQ-001 SHALL have parameter N_HARTS, default 1, number of harts served (range 1..8).
REQ-002 SHALL have parameter PRESCALE_W, default 8, width of the tick prescaler (range 1..16).
REQ-003 SHALL have one clock and reset: clk input 1, sole clock; reset asynchronous, active-low.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have paddr  input  16  APB byte address.
REQ-006 SHALL have psel / penable / pwrite  input  1 each  APB controls.
REQ-007 SHALL have pwdata  input  32  APB write data.
REQ-008 SHALL have prdata  output  32  APB read data, combinational from paddr.
REQ-009 SHALL have pready  output  1  tied 1 (zero wait states).
REQ-010 SHALL have pslverr  output  1  error response.
REQ-011 SHALL have dbg_halt  input  1  freezes time while high.
REQ-012 SHALL have tick  input  1  level-sensitive, synchronous to clk, one event per high cycle.
REQ-013 SHALL have soft_irq  output  N_HARTS  per-hart software interrupt (registered).
REQ-014 SHALL have timer_irq  output  N_HARTS  per-hart timer interrupt (registered).

Function
REQ-015 SHALL decode the map: 0x0000 CTRL (bit0 en, RW); 0x0004 PRESCALE (bits PRESCALE_W-1:0, RW); 0x0008 MTIME; 0x000C MTIMEH; 0x0100+4h MSIP[h] (bit0, RW); 0x0200+8h MTIMECMP[h]; 0x0204+8h MTIMECMPH[h].
REQ-016 SHALL complete a transfer when psel && penable; writes and read side effects take effect on that cycle's clock edge only.
REQ-017 SHALL assert pslverr, return prdata 0 and ignore writes for unmapped addresses, including MSIP/MTIMECMP with h >= N_HARTS.
REQ-018 SHALL read unimplemented bits of mapped registers as 0 and ignore writes to them.
REQ-019 SHALL form tick_now = tick && en && !dbg_halt.
REQ-020 SHALL on tick_now: if presc_cnt == PRESCALE then presc_cnt <= 0 and mtime increments by 1, else presc_cnt increments; PRESCALE=0 gives one mtime increment per tick_now.
REQ-021 SHALL reset presc_cnt to 0 on any PRESCALE write; presc_cnt holds while tick_now is low.
REQ-022 SHALL wrap mtime from 2^64-1 to 0 with no flag.
REQ-023 SHALL on a MTIME or MTIMEH write replace only that 32-bit half and suppress any increment in that cycle (write wins, no carry into the other half); presc_cnt still advances.
REQ-024 SHALL on a completed read of MTIME capture mtime[63:32] (pre-edge value) into mtimeh_shadow; a read of MTIMEH returns mtimeh_shadow, giving a coherent 64-bit sample for low-then-high reads.
REQ-025 SHALL update mtimeh_shadow on an MTIMEH write to the written value.
REQ-026 SHALL store MTIMECMP[h] as 64 bits; each half is written independently; reads return the stored value.
REQ-027 SHALL register timer_irq[h] <= (mtime >= MTIMECMP[h]), unsigned 64-bit compare on current register values, one cycle latency.
REQ-028 SHALL register soft_irq[h] <= MSIP[h]; writing bit0 sets or clears it; a write to CTRL does not affect MSIP.
REQ-029 SHALL leave mtime, presc_cnt and all compare state frozen while en=0 or dbg_halt=1; bus accesses remain functional.

Reset
REQ-030 SHALL on rst_n low asynchronously set: en=1, PRESCALE=0, presc_cnt=0, mtime=0, mtimeh_shadow=0, every MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF, MSIP=0, soft_irq=0, timer_irq=0.
REQ-031 SHALL release from reset with timer_irq low (mtime 0 < compare all-ones) until software programs MTIMECMP.
REQ-032 SHALL abandon any in-flight transfer on reset with no register side effect.

Verification
REQ-033 PRESCALE=3, tick held high 12 cycles -> mtime advances exactly 3.
REQ-034 mtime=0x0000_0000_FFFF_FFFF, tick high, read MTIME then MTIMEH across the carry -> returns 0xFFFF_FFFF then 0x0000_0000 (shadow), next MTIMEH read after another MTIME read returns 1.
REQ-035 N_HARTS=2, MTIMECMP[1]=5, PRESCALE=0, tick high -> timer_irq[1] rises the cycle after mtime reaches 5, timer_irq[0] stays 0.
REQ-036 Write MSIP[1]=1 then CTRL=0x1 -> soft_irq=2'b10 one cycle after the MSIP write, unchanged by the CTRL write.
REQ-037 dbg_halt high 10 cycles with tick high -> mtime and presc_cnt unchanged; resume counting on release.
REQ-038 Access 0x0208 with N_HARTS=1 -> pslverr=1, prdata=0, no state change; write to MTIME coinciding with tick_now -> mtime equals written value exactly.
